// File: rtl/seq_detect_pkg.sv
// Shared limits, reset-default configuration and the pattern-length clamp
// used by the serial sequence detector.
package seq_detect_pkg;

   localparam int MIN_LEN     = 2;
   localparam int MAX_PAT_W   = 16;
   localparam int DEF_LEN     = 2;
   localparam bit DEF_OVERLAP = 1'b1;

   // Requested length forced into [MIN_LEN, max_len].
   function automatic int clamp_len(input int len, input int max_len);
      if (len < MIN_LEN)
         return MIN_LEN;
      else if (len > max_len)
         return max_len;
      else
         return len;
   endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Control/data bundle of the sequence detector; master drives stimulus and
// configuration, slave is the detector itself.
interface seq_detect_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   localparam int LW = $clog2(PAT_W + 1);

   logic             clear;
   logic             cfg_load;
   logic [PAT_W-1:0] pattern;
   logic [LW-1:0]    pat_len;
   logic             overlap;
   logic             in_valid;
   logic             inbits;
   logic             detect;
   logic [CNT_W-1:0] match_count;
   logic             count_sat;

   modport master (
      output clear, cfg_load, pattern, pat_len, overlap, in_valid, inbits,
      input  detect, match_count, count_sat
   );

   modport slave (
      input  clear, cfg_load, pattern, pat_len, overlap, in_valid, inbits,
      output detect, match_count, count_sat
   );
endinterface

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is registered alongside
// the count so both change on the same edge.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         sat
);

   logic [W-1:0] cnt_next;

   always_comb begin
      cnt_next = count;
      if (clr)
         cnt_next = '0;
      else if (inc && (count != '1))
         cnt_next = count + W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= cnt_next;
         sat   <= (cnt_next == '1);
      end
   end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: shifts in bits, compares the newest len_q bits
// against a loaded pattern and pulses detect one cycle after a match.
module seq_detect
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic      clk,
   input  logic      reset_n,
   seq_detect_if.slave bus
);

   localparam int LW = $clog2(PAT_W + 1);

   if (PAT_W < MIN_LEN || PAT_W > MAX_PAT_W) begin : g_bad_width
      $error("seq_detect: PAT_W out of range");
   end

   logic [PAT_W-1:0] pat_q;
   logic [LW-1:0]    len_q;
   logic             ov_q;
   logic [PAT_W-1:0] hist, hist_next, len_mask;
   logic [LW-1:0]    fill, fill_next, len_cap;
   logic             match, detect_q;

   assign len_cap   = LW'(clamp_len(int'(bus.pat_len), PAT_W));
   assign hist_next = {hist[PAT_W-2:0], bus.inbits};
   assign fill_next = (fill == LW'(PAT_W)) ? fill : fill + LW'(1);

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < PAT_W; i++)
         len_mask[i] = (i < int'(len_q));
   end

   // A bit arriving alongside clear or cfg_load is dropped, so it cannot match.
   assign match = bus.in_valid && !bus.clear && !bus.cfg_load &&
                  (fill_next >= len_q) &&
                  (((hist_next ^ pat_q) & len_mask) == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat_q <= '1;
         len_q <= LW'(DEF_LEN);
         ov_q  <= DEF_OVERLAP;
      end else if (bus.cfg_load) begin
         pat_q <= bus.pattern;
         len_q <= len_cap;
         ov_q  <= bus.overlap;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist <= '0;
         fill <= '0;
      end else if (bus.clear || bus.cfg_load) begin
         hist <= '0;
         fill <= '0;
      end else if (bus.in_valid) begin
         hist <= hist_next;
         // Non-overlapping mode restarts the fill so the next match needs fresh bits.
         fill <= (match && !ov_q) ? '0 : fill_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         detect_q <= 1'b0;
      else
         detect_q <= match;
   end

   assign bus.detect = detect_q;

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (match),
      .clr     (bus.clear),
      .count   (bus.match_count),
      .sat     (bus.count_sat)
   );

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench: stimulus queues expected detect events, a negedge monitor
// pops them when detect fires and checks cycle, count and saturation.
module tb_seq_detect;

   localparam int PAT_W = 4;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int c;
      int cnt;
      bit sat;
   } exp_t;
   exp_t q[$];

   seq_detect_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) ifc ();

   seq_detect #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every detect pulse must correspond to a queued expectation.
   always @(negedge clk) begin
      if (reset_n && ifc.detect) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_detect: got detect at cyc %0d want none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("detect_cycle", cyc, e.c);
            chk("detect_count", int'(ifc.match_count), e.cnt);
            chk("detect_sat", int'(ifc.count_sat), int'(e.sat));
         end
      end
   end

   task automatic step(input bit v, input bit b, input bit clr, input bit ld,
                       input bit ed, input int ecnt, input bit esat);
      @(negedge clk);
      ifc.in_valid = v;
      ifc.inbits   = b;
      ifc.clear    = clr;
      ifc.cfg_load = ld;
      if (ed) q.push_back('{cyc + 1, ecnt, esat});
   endtask

   task automatic bx(input bit b);
      step(1'b1, b, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic bd(input bit b, input int ecnt, input bit esat);
      step(1'b1, b, 1'b0, 1'b0, 1'b1, ecnt, esat);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   // Clear and load both carry a valid '1' bit that must be discarded.
   task automatic do_clear();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic load(input logic [PAT_W-1:0] pat, input logic [2:0] len, input bit ov);
      ifc.pattern = pat;
      ifc.pat_len = len;
      ifc.overlap = ov;
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
   endtask

   initial begin
      ifc.clear = 1'b0; ifc.cfg_load = 1'b0; ifc.pattern = '0; ifc.pat_len = '0;
      ifc.overlap = 1'b0; ifc.in_valid = 1'b0; ifc.inbits = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_detect", int'(ifc.detect), 0);
      chk("reset_count", int'(ifc.match_count), 0);
      chk("reset_sat", int'(ifc.count_sat), 0);
      reset_n = 1'b1;

      // Defaults: "11" with overlap
      bx(0); bx(1); bd(1, 1, 0); bd(1, 2, 0); bx(0); bx(1); bd(1, 3, 1);
      idle();
      chk("default_count", int'(ifc.match_count), 3);
      do_clear(); idle();
      chk("clear_count", int'(ifc.match_count), 0);
      chk("clear_sat", int'(ifc.count_sat), 0);

      // 1011, overlap then non-overlap; cfg_load keeps the count
      load(4'b1011, 3'd4, 1'b1);
      bx(1); bx(0); bx(1); bd(1, 1, 0); bx(0); bx(1); bd(1, 2, 0);
      load(4'b1011, 3'd4, 1'b0);
      bx(1); bx(0); bx(1); bd(1, 3, 1); bx(0); bx(1); bx(1);
      idle();
      chk("nonovl_count", int'(ifc.match_count), 3);
      do_clear();

      // Gapped stream, then clear on the completing bit
      bx(1); idle(); bx(0); idle(); bx(1); idle(); bd(1, 1, 0); idle(); idle();
      chk("gap_count", int'(ifc.match_count), 1);
      bx(1); bx(0); bx(1); do_clear(); idle(); idle();
      chk("clear_discard_count", int'(ifc.match_count), 0);
      bx(1); bx(0); bx(1); bd(1, 1, 0); idle();
      do_clear();

      // pat_len=0 clamps to 2; count saturates at 3 and detect keeps pulsing
      load(4'b1111, 3'd0, 1'b1);
      bx(1); bd(1, 1, 0); bd(1, 2, 0); bd(1, 3, 1); bd(1, 3, 1); bd(1, 3, 1);
      idle();
      chk("sat_count", int'(ifc.match_count), 3);
      chk("sat_flag", int'(ifc.count_sat), 1);
      do_clear(); idle();
      chk("sat_cleared", int'(ifc.count_sat), 0);

      // pat_len=PAT_W+1 clamps to PAT_W: 1110 must not hit, 0110 must
      load(4'b0110, 3'd5, 1'b1);
      bx(1); bx(1); bx(1); bx(0); bx(1); bx(1); bd(0, 1, 0);
      idle();
      do_clear();

      // Async reset right after a detect; config returns to defaults
      load(4'b1011, 3'd4, 1'b1);
      bx(1); bx(0); bx(1); bx(1);
      @(posedge clk); #1;
      chk("pre_reset_detect", int'(ifc.detect), 1);
      chk("pre_reset_count", int'(ifc.match_count), 1);
      ifc.in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("async_detect", int'(ifc.detect), 0);
      chk("async_count", int'(ifc.match_count), 0);
      chk("async_sat", int'(ifc.count_sat), 0);
      @(negedge clk); reset_n = 1'b1;
      bx(1); bd(1, 1, 0);
      idle(); idle(); idle();
      chk("pending", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
